// File: rtl/vga_scan_driver.sv
// vga_scan_driver: raster-scan timing generator for the VGA display path.
// Divides the system clock down to a pixel tick and walks xpos/ypos across
// the full line and frame. Sync and blanking terms go through a short delay
// line so that they line up with renderer colour returning PIPE ticks after
// its coordinate. RGB, hsync and vsync are registered on pixel ticks. Also
// produces a frame-start pulse and an animation toggle every ANIM_FRAMES
// frames.
module vga_scan_driver #(
  parameter int CLK_DIV     = 2,
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int PIPE        = 0,
  parameter int ANIM_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] color,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       pix_tick,
  output logic       active,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       animation_cycle
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] ANIM_LAST = 10'(ANIM_FRAMES - 1);

  // Delay-line entry for a blank, sync-inactive pixel: {hs, vs, active}.
  localparam logic [2:0] IDLE_TERMS = 3'b110;

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic             pix_tick_r;
  logic [9:0]       xpos_r;
  logic [9:0]       ypos_r;
  logic [9:0]       x_nxt_s;
  logic [9:0]       y_nxt_s;
  logic             wrap_s;
  logic             frame_start_r;
  logic [9:0]       frame_cnt_r;
  logic             anim_r;
  logic             active_s;
  logic             hs_raw_s;
  logic             vs_raw_s;
  logic [2:0]       raw_s;
  logic [2:0]       dly_s;
  logic [7:0]       rgb_r;
  logic             hsync_r;
  logic             vsync_r;

  // Next divider value; wraps after CLK_DIV-1.
  always_comb begin
    div_nxt_s = div_r;
    if (div_r == DIV_LAST) begin
      div_nxt_s = '0;
    end else begin
      div_nxt_s = div_r + DIV_W'(1);
    end
  end

  // Divider and pixel tick; the tick is pre-computed so it is high exactly
  // while the divider holds its last value, and low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r      <= '0;
      pix_tick_r <= 1'b0;
    end else begin
      div_r      <= div_nxt_s;
      pix_tick_r <= (div_nxt_s == DIV_LAST);
    end
  end

  // Next scan position; wrap_s flags the (last,last) -> (0,0) transition.
  always_comb begin
    x_nxt_s = xpos_r;
    y_nxt_s = ypos_r;
    wrap_s  = 1'b0;
    if (pix_tick_r) begin
      if (xpos_r == H_LAST) begin
        x_nxt_s = 10'd0;
        if (ypos_r == V_LAST) begin
          y_nxt_s = 10'd0;
          wrap_s  = 1'b1;
        end else begin
          y_nxt_s = ypos_r + 10'd1;
        end
      end else begin
        x_nxt_s = xpos_r + 10'd1;
      end
    end else begin
      x_nxt_s = xpos_r;
      y_nxt_s = ypos_r;
    end
  end

  // Scan counters, frame pulse and animation state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpos_r        <= 10'd0;
      ypos_r        <= 10'd0;
      frame_start_r <= 1'b0;
      frame_cnt_r   <= 10'd0;
      anim_r        <= 1'b0;
    end else begin
      xpos_r        <= x_nxt_s;
      ypos_r        <= y_nxt_s;
      frame_start_r <= wrap_s;
      if (wrap_s) begin
        if (frame_cnt_r == ANIM_LAST) begin
          frame_cnt_r <= 10'd0;
          anim_r      <= ~anim_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + 10'd1;
        end
      end
    end
  end

  // Undelayed visibility and sync terms for the coordinate now presented.
  always_comb begin
    active_s = (xpos_r < H_VIS) && (ypos_r < V_VIS);
    hs_raw_s = !((xpos_r >= HS_START) && (xpos_r < HS_END));
    vs_raw_s = !((ypos_r >= VS_START) && (ypos_r < VS_END));
    raw_s    = {hs_raw_s, vs_raw_s, active_s};
  end

  generate
    if (PIPE == 0) begin : g_no_pipe
      assign dly_s = raw_s;
    end else begin : g_pipe
      logic [2:0] stage_r [PIPE];

      // Align sync/blank terms with the renderer latency, one stage per tick.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE; i++) begin
            stage_r[i] <= IDLE_TERMS;
          end
        end else if (pix_tick_r) begin
          stage_r[0] <= raw_s;
          for (int i = 1; i < PIPE; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign dly_s = stage_r[PIPE-1];
    end
  endgenerate

  // Pin register: colour only while the aligned pixel is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_r   <= 8'h00;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else if (pix_tick_r) begin
      rgb_r   <= dly_s[0] ? color : 8'h00;
      hsync_r <= dly_s[2];
      vsync_r <= dly_s[1];
    end
  end

  assign xpos            = xpos_r;
  assign ypos            = ypos_r;
  assign pix_tick        = pix_tick_r;
  assign active          = active_s;
  assign vga_r           = rgb_r[7:5];
  assign vga_g           = rgb_r[4:2];
  assign vga_b           = rgb_r[1:0];
  assign hsync           = hsync_r;
  assign vsync           = vsync_r;
  assign frame_start     = frame_start_r;
  assign animation_cycle = anim_r;

endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: checks the scan driver against a pixel-index model.
// The model numbers pixel ticks since reset; positions, sync windows,
// colour latency, frame pulses and the animation phase all follow from that
// index by plain division and modulo. The timing is shrunk so several
// frames fit in a short run.
module tb_vga_scan_driver;

  localparam int DIV  = 2;
  localparam int HV   = 8;
  localparam int HF   = 2;
  localparam int HS   = 3;
  localparam int HB   = 2;
  localparam int VV   = 6;
  localparam int VF   = 1;
  localparam int VS   = 2;
  localparam int VB   = 1;
  localparam int PIPE = 2;
  localparam int ANIM = 3;
  localparam int HTOT = HV + HF + HS + HB;
  localparam int VTOT = VV + VF + VS + VB;
  localparam int FRAME = HTOT * VTOT;

  logic       clk;
  logic       rst_n;
  logic [7:0] color;
  logic [9:0] xpos;
  logic [9:0] ypos;
  logic       pix_tick;
  logic       active;
  logic [2:0] vga_r;
  logic [2:0] vga_g;
  logic [1:0] vga_b;
  logic       hsync;
  logic       vsync;
  logic       frame_start;
  logic       animation_cycle;

  int checks   = 0;
  int failures = 0;
  int c        = 0;
  int fs_seen  = 0;
  logic [7:0] col_hist [0:4095];

  vga_scan_driver #(
    .CLK_DIV(DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIPE(PIPE), .ANIM_FRAMES(ANIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .color(color),
    .xpos(xpos), .ypos(ypos), .pix_tick(pix_tick), .active(active),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
    .animation_cycle(animation_cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (clk %0d)", tag, obs, exp, c);
    end
  endtask

  function automatic int px(input int m);
    return m % HTOT;
  endfunction

  function automatic int py(input int m);
    return (m / HTOT) % VTOT;
  endfunction

  function automatic bit vis(input int m);
    return (px(m) < HV) && (py(m) < VV);
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_xpos"}, 32'(xpos), 32'd0);
    check({tag, "_ypos"}, 32'(ypos), 32'd0);
    check({tag, "_tick"}, 32'(pix_tick), 32'd0);
    check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    check({tag, "_hsync"}, 32'(hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vsync), 32'd1);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
    check({tag, "_anim"}, 32'(animation_cycle), 32'd0);
  endtask

  // Compare every output after posedge number c since reset release.
  task automatic check_all();
    int n;
    int m;
    bit exp_hs;
    bit exp_vs;
    logic [7:0] exp_rgb;
    n = c / DIV;
    m = n - 1 - PIPE;
    exp_hs  = 1'b1;
    exp_vs  = 1'b1;
    exp_rgb = 8'h00;
    if (n >= 1 && m >= 0) begin
      exp_hs  = !(px(m) >= HV + HF && px(m) < HV + HF + HS);
      exp_vs  = !(py(m) >= VV + VF && py(m) < VV + VF + VS);
      exp_rgb = vis(m) ? col_hist[n] : 8'h00;
    end
    check("pix_tick", 32'(pix_tick), 32'((c % DIV) == DIV - 1));
    check("xpos", 32'(xpos), 32'(px(n)));
    check("ypos", 32'(ypos), 32'(py(n)));
    check("active", 32'(active), 32'(vis(n)));
    check("hsync", 32'(hsync), 32'(exp_hs));
    check("vsync", 32'(vsync), 32'(exp_vs));
    check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
    check("frame_start", 32'(frame_start),
          32'((c % DIV) == 0 && n > 0 && (n % FRAME) == 0));
    check("anim", 32'(animation_cycle), 32'(((n / FRAME) / ANIM) % 2));
  endtask

  task automatic run(input int nclk);
    for (int k = 0; k < nclk; k++) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if ((c % DIV) == 0) col_hist[c / DIV] = color;
      if (frame_start) fs_seen++;
      check_all();
      color = 8'($urandom_range(255, 0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    color = 8'hE0;
    repeat (3) @(negedge clk);
    check_reset("por");

    // Seven frames and a bit: animation rises at frame 3, falls at frame 6.
    rst_n = 1'b1;
    c = 0;
    fs_seen = 0;
    run(DIV * (7 * FRAME + 37));
    check("fs_count", 32'(fs_seen), 32'd7);

    // Restart and stop mid-frame while animation_cycle is high.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    run(DIV * (4 * FRAME + 77));
    check("pre_reset_anim", 32'(animation_cycle), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    run(DIV * 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
